tlb_unit: RTL
=============

// Module: tlb_unit
// PURPOSE
//  MMU end of CP0_MMU_Interface: 16-entry fully associative MIPS32 joint TLB.
//  Executes TLBWI/TLBWR/TLBR/TLBP from WB on CP0_* fields; returns MMU_* to CP0.
//  Two combinational lookup ports: s0 = IF fetch, s1 = MEM data.
//  Exception decisions (refill/invalid/modified) are made by the callers.
// PARAMETERS
//  TLBNUM    16  number of entries, power of 2
//  IDX_W     4   log2(TLBNUM); width of CP0_index/MMU_index
// PORTS
//  clk              in   1   core clock
//  rst              in   1   async reset, active-high
//  tlbwi/tlbwr      in   1   write-indexed / write-random command, 1-cycle pulse
//  tlbr/tlbp        in   1   read-indexed / probe command, 1-cycle pulse
//  CP0_vpn2/asid    in   19/8     EntryHi fields
//  CP0_{pfn,c,d,v,g}0/1  in  20/3/1/1/1  EntryLo0/1 fields
//  CP0_index        in   IDX_W  Index register
//  MMU_vpn2..MMU_g1 out  as CP0_*  registered TLBR result
//  MMU_index        out  IDX_W  registered TLBP hit index
//  MMU_probe_miss   out  1   registered; 1 = TLBP found no match (Index.P)
//  MMU_rvalid       out  1   pulse, TLBR result valid
//  MMU_pvalid       out  1   pulse, TLBP result valid
//  s0/s1_vpn2       in   19  lookup VA[31:13]
//  s0/s1_odd        in   1   lookup VA[12]
//  s0/s1_asid       in   8   current ASID
//  s0/s1_found      out  1   hit
//  s0/s1_{pfn,c,d,v} out 20/3/1/1  selected half of the hit entry
// BEHAVIOUR
//  - Reset: all entries cleared (V0=V1=0, G=0), random = TLBNUM-1.
//    All MMU_* outputs, MMU_probe_miss, MMU_rvalid and MMU_pvalid are 0.
//  - Storage: per entry {vpn2, asid, G, pfn0,c0,d0,v0, pfn1,c1,d1,v1}.
//    Stored G = CP0_g0 & CP0_g1.
//  - Command priority if >1 asserted (illegal): tlbp > tlbr > tlbwi > tlbwr; only the winner acts.
//  - TLBWI: entry[CP0_index] written at the posedge of the command cycle.
//    s0/s1/TLBP in the next cycle see the new contents. No same-cycle bypass.
//  - TLBWR: as TLBWI, but the index comes from the random counter (see CONFIGURATION).
//  - TLBR: at the posedge, MMU_* <= entry[CP0_index] and MMU_rvalid <= 1 for one cycle.
//    MMU_g0 = MMU_g1 = stored G.
//  - TLBP: match = (vpn2 equal) & (G | asid equal); the lowest matching index wins.
//    Hit: MMU_index <= idx, MMU_probe_miss <= 0. Miss: MMU_probe_miss <= 1, MMU_index holds.
//    MMU_pvalid pulses 1 cycle. Latency 1 for TLBR and TLBP.
//  - Unaffected MMU_* registers hold their values across cycles.
//  - Lookup (comb, 0 latency): match rule as TLBP; lowest index wins on multi-hit.
//    Half selected by odd. On miss, found=0 and pfn/c/d/v = 0.
//  - The random counter decrements every cycle, wrapping 0 -> TLBNUM-1.
//  - rst asserted mid-command: no write occurs; valid pulses are forced to 0.
// CONFIGURATION
//  TLB_RANDOM_EN defined: TLBWR index = random counter value (Random reg semantics).
//  Not defined: the counter is removed; TLBWR writes entry[CP0_index], identical to TLBWI.
// STRUCTURE
//  Add to CPU_Defines.svh:
//    - TLBEntryType packed struct
//    - `TLBNUM and `TLB_IDX_W constants
//    - TLBCmdType {tlbp,tlbr,tlbwi,tlbwr}
//  Add an MMU_probe_miss/MMU_rvalid/MMU_pvalid extension to CP0_MMU_Interface (MMU modport).
//  Sub-module tlb_match: one entry array x one {vpn2,asid} -> {hit, idx}, lowest-index priority.
//  tlb_match is instantiated 3x (s0, s1, probe).
// TESTING
//  1. Reset, then s0 lookup vpn2=0x00012 asid=5 -> s0_found=0.
//     Outputs all 0. After TLBR of idx 0: MMU_v0=MMU_v1=0.
//  2. TLBWI idx3 {vpn2=0x00012, asid=5, g0=g1=0, pfn0=0x100 v0=1, pfn1=0x101 v1=1 d1=1 c1=3}.
//     Next cycle, s1 lookup odd=1 asid=5 -> found=1, pfn=0x101, d=1, c=3.
//     Same lookup with asid=6 -> found=0.
//  3. Write g0=1,g1=0 -> stored G=0; asid mismatch misses.
//     Rewrite g0=g1=1 -> asid=0xFF hits. TLBR shows MMU_g0=MMU_g1=1.
//  4. TLBP vpn2=0x00012 asid=5 -> next cycle MMU_pvalid=1, MMU_index=3, probe_miss=0.
//     TLBP vpn2=0x7FFFF -> probe_miss=1, MMU_index stays 3.
//     Duplicate vpn2 in idx1 and idx3 -> index=1.
//  5. With TLB_RANDOM_EN: release reset at T0, issue TLBWR at T0+k -> write lands at (15-k) mod 16.
//     TLBR of that index confirms. Without the macro, the same TLBWR lands at CP0_index.
//  6. tlbwi=1 with rst=1 in the same cycle -> entry unchanged, lookup misses.
//     tlbp+tlbwi together -> only the probe acts.

Source files
------------

// File: rtl/tlb_unit_pkg.sv
// Shared types for the joint TLB: entry layout, command decode, lookup result.
// The TLB_RANDOM_EN macro (see tlb_unit.sv) selects the TLBWR index source.
package tlb_unit_pkg;

   localparam int TLBNUM    = 16;
   localparam int TLB_IDX_W = $clog2(TLBNUM);

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } tlb_lkp_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_TLBP,
      CMD_TLBR,
      CMD_TLBWI,
      CMD_TLBWR
   } tlb_cmd_e;

   // Simultaneous commands are illegal; resolve them deterministically.
   function automatic tlb_cmd_e decode_cmd(input logic p, input logic r,
                                           input logic wi, input logic wr);
      if (p)  return CMD_TLBP;
      if (r)  return CMD_TLBR;
      if (wi) return CMD_TLBWI;
      if (wr) return CMD_TLBWR;
      return CMD_NONE;
   endfunction

   function automatic tlb_lkp_t sel_half(input tlb_entry_t e, input logic odd,
                                         input logic hit);
      tlb_lkp_t r;
      r = '0;
      if (hit) r = odd ? {e.pfn1, e.c1, e.d1, e.v1} : {e.pfn0, e.c0, e.d0, e.v0};
      return r;
   endfunction

endpackage

// File: rtl/tlb_unit_if.sv
// CP0 <-> MMU bus: TLB maintenance commands/results plus the two lookup ports.
// master = CP0 and pipeline callers, slave = the TLB.
interface tlb_unit_if;
   logic        tlbwi, tlbwr, tlbr, tlbp;
   logic [18:0] CP0_vpn2;
   logic [7:0]  CP0_asid;
   logic [19:0] CP0_pfn0, CP0_pfn1;
   logic [2:0]  CP0_c0, CP0_c1;
   logic        CP0_d0, CP0_v0, CP0_g0, CP0_d1, CP0_v1, CP0_g1;
   logic [3:0]  CP0_index;

   logic [18:0] MMU_vpn2;
   logic [7:0]  MMU_asid;
   logic [19:0] MMU_pfn0, MMU_pfn1;
   logic [2:0]  MMU_c0, MMU_c1;
   logic        MMU_d0, MMU_v0, MMU_g0, MMU_d1, MMU_v1, MMU_g1;
   logic [3:0]  MMU_index;
   logic        MMU_probe_miss, MMU_rvalid, MMU_pvalid;

   logic [18:0] s0_vpn2, s1_vpn2;
   logic        s0_odd, s1_odd;
   logic [7:0]  s0_asid, s1_asid;
   logic        s0_found, s1_found;
   logic [19:0] s0_pfn, s1_pfn;
   logic [2:0]  s0_c, s1_c;
   logic        s0_d, s0_v, s1_d, s1_v;

   modport master (
      output tlbwi, tlbwr, tlbr, tlbp, CP0_vpn2, CP0_asid, CP0_pfn0, CP0_pfn1,
             CP0_c0, CP0_c1, CP0_d0, CP0_v0, CP0_g0, CP0_d1, CP0_v1, CP0_g1, CP0_index,
             s0_vpn2, s1_vpn2, s0_odd, s1_odd, s0_asid, s1_asid,
      input  MMU_vpn2, MMU_asid, MMU_pfn0, MMU_pfn1, MMU_c0, MMU_c1, MMU_d0, MMU_v0,
             MMU_g0, MMU_d1, MMU_v1, MMU_g1, MMU_index, MMU_probe_miss, MMU_rvalid,
             MMU_pvalid, s0_found, s1_found, s0_pfn, s1_pfn, s0_c, s1_c,
             s0_d, s0_v, s1_d, s1_v
   );

   modport slave (
      input  tlbwi, tlbwr, tlbr, tlbp, CP0_vpn2, CP0_asid, CP0_pfn0, CP0_pfn1,
             CP0_c0, CP0_c1, CP0_d0, CP0_v0, CP0_g0, CP0_d1, CP0_v1, CP0_g1, CP0_index,
             s0_vpn2, s1_vpn2, s0_odd, s1_odd, s0_asid, s1_asid,
      output MMU_vpn2, MMU_asid, MMU_pfn0, MMU_pfn1, MMU_c0, MMU_c1, MMU_d0, MMU_v0,
             MMU_g0, MMU_d1, MMU_v1, MMU_g1, MMU_index, MMU_probe_miss, MMU_rvalid,
             MMU_pvalid, s0_found, s1_found, s0_pfn, s1_pfn, s0_c, s1_c,
             s0_d, s0_v, s1_d, s1_v
   );
endinterface

// File: rtl/tlb_unit_match.sv
// Associative match of one {vpn2, asid} against every entry; lowest index wins.
module tlb_match
   import tlb_unit_pkg::*;
(
   input  tlb_entry_t [TLBNUM-1:0] entries,
   input  logic [18:0]             vpn2,
   input  logic [7:0]              asid,
   output logic                    hit,
   output logic [TLB_IDX_W-1:0]    idx
);
   logic [TLBNUM-1:0] m;

   for (genvar i = 0; i < TLBNUM; i++) begin : g_cmp
      assign m[i] = (entries[i].vpn2 == vpn2) && (entries[i].g || entries[i].asid == asid);
   end

   assign hit = |m;

   // Scan downward so the lowest matching index is the last one assigned.
   always_comb begin
      idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--)
         if (m[i]) idx = TLB_IDX_W'(i);
   end
endmodule

// File: rtl/tlb_unit.sv
// 16-entry fully associative MIPS32 joint TLB: TLBWI/TLBWR/TLBR/TLBP plus two lookup ports.
// Define TLB_RANDOM_EN to give TLBWR a free-running Random index; otherwise TLBWR uses CP0_index.
module tlb_unit
   import tlb_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   tlb_unit_if.slave bus
);
   tlb_entry_t [TLBNUM-1:0]       entries;
   tlb_entry_t                    wr_entry, rd_q;
   tlb_cmd_e                      cmd;
   logic [2:0][18:0]              q_vpn2;
   logic [2:0][7:0]               q_asid;
   logic [2:0]                    q_hit;
   logic [2:0][TLB_IDX_W-1:0]     q_idx;
   logic [TLB_IDX_W-1:0]          wr_idx, index_q;
   logic                          probe_miss_q, rvalid_q, pvalid_q;
   tlb_lkp_t                      s0_res, s1_res;

   assign cmd = decode_cmd(bus.tlbp, bus.tlbr, bus.tlbwi, bus.tlbwr);

   // Slot 0 = fetch, 1 = data, 2 = TLBP probe.
   assign q_vpn2 = {bus.CP0_vpn2, bus.s1_vpn2, bus.s0_vpn2};
   assign q_asid = {bus.CP0_asid, bus.s1_asid, bus.s0_asid};

   for (genvar k = 0; k < 3; k++) begin : g_match
      tlb_match u_match (
         .entries (entries),
         .vpn2    (q_vpn2[k]),
         .asid    (q_asid[k]),
         .hit     (q_hit[k]),
         .idx     (q_idx[k])
      );
   end

   assign s0_res       = sel_half(entries[q_idx[0]], bus.s0_odd, q_hit[0]);
   assign s1_res       = sel_half(entries[q_idx[1]], bus.s1_odd, q_hit[1]);
   assign bus.s0_found = q_hit[0];
   assign bus.s0_pfn   = s0_res.pfn;
   assign bus.s0_c     = s0_res.c;
   assign bus.s0_d     = s0_res.d;
   assign bus.s0_v     = s0_res.v;
   assign bus.s1_found = q_hit[1];
   assign bus.s1_pfn   = s1_res.pfn;
   assign bus.s1_c     = s1_res.c;
   assign bus.s1_d     = s1_res.d;
   assign bus.s1_v     = s1_res.v;

   // A page pair is global only if both halves say so.
   assign wr_entry = '{vpn2: bus.CP0_vpn2, asid: bus.CP0_asid, g: bus.CP0_g0 & bus.CP0_g1,
                       pfn0: bus.CP0_pfn0, c0: bus.CP0_c0, d0: bus.CP0_d0, v0: bus.CP0_v0,
                       pfn1: bus.CP0_pfn1, c1: bus.CP0_c1, d1: bus.CP0_d1, v1: bus.CP0_v1};

`ifdef TLB_RANDOM_EN
   logic [TLB_IDX_W-1:0] random_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) random_q <= TLB_IDX_W'(TLBNUM - 1);
      else     random_q <= random_q - TLB_IDX_W'(1);

   assign wr_idx = (cmd == CMD_TLBWR) ? random_q : bus.CP0_index;
`else
   assign wr_idx = bus.CP0_index;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst)
         entries <= '0;
      else if (cmd == CMD_TLBWI || cmd == CMD_TLBWR)
         entries[wr_idx] <= wr_entry;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_q         <= '0;
         index_q      <= '0;
         probe_miss_q <= 1'b0;
         rvalid_q     <= 1'b0;
         pvalid_q     <= 1'b0;
      end else begin
         rvalid_q <= (cmd == CMD_TLBR);
         pvalid_q <= (cmd == CMD_TLBP);
         if (cmd == CMD_TLBR) rd_q <= entries[bus.CP0_index];
         if (cmd == CMD_TLBP) begin
            probe_miss_q <= ~q_hit[2];
            if (q_hit[2]) index_q <= q_idx[2];
         end
      end

   assign bus.MMU_vpn2       = rd_q.vpn2;
   assign bus.MMU_asid       = rd_q.asid;
   assign bus.MMU_g0         = rd_q.g;
   assign bus.MMU_g1         = rd_q.g;
   assign bus.MMU_pfn0       = rd_q.pfn0;
   assign bus.MMU_c0         = rd_q.c0;
   assign bus.MMU_d0         = rd_q.d0;
   assign bus.MMU_v0         = rd_q.v0;
   assign bus.MMU_pfn1       = rd_q.pfn1;
   assign bus.MMU_c1         = rd_q.c1;
   assign bus.MMU_d1         = rd_q.d1;
   assign bus.MMU_v1         = rd_q.v1;
   assign bus.MMU_index      = index_q;
   assign bus.MMU_probe_miss = probe_miss_q;
   assign bus.MMU_rvalid     = rvalid_q;
   assign bus.MMU_pvalid     = pvalid_q;
endmodule
